// File: rtl/frame_generator.sv
// Ethernet-style test frame generator: Avalon-configured header and seeded payload,
// streamed as 16-bit words on an AXI-stream egress with per-frame payload checksum.
module frame_generator #(
  parameter int DEFAULT_LEN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  writedata,
  input  logic        write,
  input  logic        chipselect,
  input  logic [7:0]  address,
  input  logic        read,
  output logic [7:0]  readdata,
  output logic [15:0] egress_port_tdata,
  output logic        egress_port_tvalid,
  input  logic        egress_port_tready,
  output logic        egress_port_tlast
);
  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
  state_t state, state_nxt;

  logic [5:0][7:0] dst_mac, src_mac, sh_dst, sh_src;
  logic [7:0]  eth_lo, eth_hi, len_reg, seed;
  logic [15:0] sh_eth;
  logic [7:0]  sh_len, sh_seed;
  logic        continuous, stop_pend;
  logic [2:0]  hdr_idx;
  logic [7:0]  pay_idx;
  logic [7:0]  frames_sent;
  logic [31:0] checksum, accum;
  logic [7:0]  rd_mux;
  logic        wr_en, ctrl_wr, start_wr, stop_wr, hs, last_hs, snap;

  assign wr_en    = chipselect && write;
  assign ctrl_wr  = wr_en && (address == 8'd16);
  assign start_wr = ctrl_wr && writedata[0];
  assign stop_wr  = ctrl_wr && writedata[2];
  assign hs       = egress_port_tvalid && egress_port_tready;
  assign last_hs  = hs && egress_port_tlast;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A stop arriving on the very cycle of the last handshake still prevents the restart.
  always_comb begin
    state_nxt = state;
    snap      = 1'b0;
    case (state)
      IDLE: if (start_wr) begin
        state_nxt = HDR;
        snap      = 1'b1;
      end
      HDR: if (hs && hdr_idx == 3'd6) state_nxt = PAY;
      PAY: if (last_hs) begin
        if (continuous && !stop_pend && !stop_wr) begin
          state_nxt = HDR;
          snap      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    egress_port_tvalid = (state != IDLE);
    egress_port_tlast  = (state == PAY) && (pay_idx == sh_len - 8'd1);
    egress_port_tdata  = '0;
    if (state == HDR) begin
      case (hdr_idx)
        3'd0:    egress_port_tdata = {sh_dst[1], sh_dst[0]};
        3'd1:    egress_port_tdata = {sh_dst[3], sh_dst[2]};
        3'd2:    egress_port_tdata = {sh_dst[5], sh_dst[4]};
        3'd3:    egress_port_tdata = {sh_src[1], sh_src[0]};
        3'd4:    egress_port_tdata = {sh_src[3], sh_src[2]};
        3'd5:    egress_port_tdata = {sh_src[5], sh_src[4]};
        3'd6:    egress_port_tdata = sh_eth;
        default: egress_port_tdata = '0;
      endcase
    end else if (state == PAY) begin
      egress_port_tdata = {sh_seed, pay_idx};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dst_mac <= '0;
      src_mac <= '0;
      eth_lo  <= '0;
      eth_hi  <= '0;
      len_reg <= 8'(DEFAULT_LEN);
      seed    <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < 6; i++) begin
        if (address == 8'(i))     dst_mac[i] <= writedata;
        if (address == 8'(i + 6)) src_mac[i] <= writedata;
      end
      case (address)
        8'd12:   eth_lo  <= writedata;
        8'd13:   eth_hi  <= writedata;
        8'd14:   len_reg <= writedata;
        8'd15:   seed    <= writedata;
        default: ;
      endcase
    end
  end

  // Stop only needs to be remembered when a frame is running or starting with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      continuous <= 1'b0;
      stop_pend  <= 1'b0;
    end else begin
      if (ctrl_wr) continuous <= writedata[1] && !writedata[2];
      if (last_hs)
        stop_pend <= 1'b0;
      else if (stop_wr && (state != IDLE || start_wr))
        stop_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_dst      <= '0;
      sh_src      <= '0;
      sh_eth      <= '0;
      sh_len      <= 8'd1;
      sh_seed     <= '0;
      hdr_idx     <= '0;
      pay_idx     <= '0;
      accum       <= '0;
      checksum    <= '0;
      frames_sent <= '0;
    end else begin
      if (snap) begin
        sh_dst  <= dst_mac;
        sh_src  <= src_mac;
        sh_eth  <= {eth_hi, eth_lo};
        sh_len  <= (len_reg == 8'd0) ? 8'd1 : len_reg;
        sh_seed <= seed;
        hdr_idx <= '0;
        pay_idx <= '0;
        accum   <= '0;
      end else if (hs) begin
        if (state == HDR) begin
          hdr_idx <= hdr_idx + 3'd1;
        end else begin
          pay_idx <= pay_idx + 8'd1;
          accum   <= accum + {16'd0, egress_port_tdata};
        end
      end
      if (last_hs) begin
        checksum    <= accum + {16'd0, egress_port_tdata};
        frames_sent <= frames_sent + 8'd1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < 6; i++) begin
      if (address == 8'(i))     rd_mux = dst_mac[i];
      if (address == 8'(i + 6)) rd_mux = src_mac[i];
    end
    case (address)
      8'd12:   rd_mux = eth_lo;
      8'd13:   rd_mux = eth_hi;
      8'd14:   rd_mux = len_reg;
      8'd15:   rd_mux = seed;
      8'd16:   rd_mux = {6'd0, continuous, 1'b0};
      8'd17:   rd_mux = {6'd0, continuous, state != IDLE};
      8'd18:   rd_mux = frames_sent;
      8'd20:   rd_mux = checksum[7:0];
      8'd21:   rd_mux = checksum[15:8];
      8'd22:   rd_mux = checksum[23:16];
      8'd23:   rd_mux = checksum[31:24];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  readdata <= '0;
    else if (chipselect && read) readdata <= rd_mux;
    else                         readdata <= '0;
  end

endmodule

// File: tb/tb_frame_generator.sv
// Directed self-checking bench for frame_generator: header/payload sequence, stalls,
// zero length, continuous mode with stop, shadowed seed and mid-frame reset.
module tb_frame_generator;
  logic        clk;
  logic        reset;
  logic [7:0]  writedata;
  logic        write;
  logic        chipselect;
  logic [7:0]  address;
  logic        read;
  logic [7:0]  readdata;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_w [0:15];
  logic [7:0]  rv;
  int          cyc;

  frame_generator #(.DEFAULT_LEN(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .writedata          (writedata),
    .write              (write),
    .chipselect         (chipselect),
    .address            (address),
    .read               (read),
    .readdata           (readdata),
    .egress_port_tdata  (tdata),
    .egress_port_tvalid (tvalid),
    .egress_port_tready (tready),
    .egress_port_tlast  (tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] e);
    logic [7:0] d;
    rd(a, d);
    chk(tag, {24'd0, d}, {24'd0, e});
  endtask

  task automatic set_payload(input logic [7:0] s, input int n);
    for (int k = 0; k < n; k++) exp_w[7 + k] = {s, 8'(k)};
  endtask

  // Called at a negedge with the word exp_w[first] already presented.
  task automatic run_words(input int first, input int cnt, input int n_total,
                           input bit toggle, output int cycles);
    int i;
    logic [15:0] hold_d;
    logic hold_l;
    bit stalled;
    i = first; cycles = 0; stalled = 0; hold_d = '0; hold_l = 1'b0;
    while (i < first + cnt && cycles < 200) begin
      tready = toggle ? cycles[0] : 1'b1;
      cycles++;
      chk("tvalid_in_frame", {31'd0, tvalid}, 32'd1);
      if (stalled) begin
        chk("stall_tdata", {16'd0, tdata}, {16'd0, hold_d});
        chk("stall_tlast", {31'd0, tlast}, {31'd0, hold_l});
      end
      if (tready) begin
        chk("word", {16'd0, tdata}, {16'd0, exp_w[i]});
        chk("tlast", {31'd0, tlast}, {31'd0, (i == n_total - 1)});
        i++;
        stalled = 0;
      end else begin
        hold_d = tdata; hold_l = tlast; stalled = 1;
      end
      @(negedge clk);
    end
    if (i < first + cnt) chk("frame_timeout", i, first + cnt);
  endtask

  initial begin
    reset = 1'b0; writedata = '0; write = 1'b0; chipselect = 1'b0;
    address = '0; read = 1'b0; tready = 1'b0;
    exp_w[0] = 16'h0201; exp_w[1] = 16'h0403; exp_w[2] = 16'h0605;
    exp_w[3] = 16'h0B0A; exp_w[4] = 16'h0D0C; exp_w[5] = 16'h0F0E;
    exp_w[6] = 16'h0800;
    for (int k = 7; k < 16; k++) exp_w[k] = '0;

    // reset state
    #12;
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_tlast", {31'd0, tlast}, 32'd0);
    chk("rst_tdata", {16'd0, tdata}, 32'd0);
    chk("rst_readdata", {24'd0, readdata}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    rd_chk("rst_count", 8'd18, 8'h00);
    rd_chk("rst_len", 8'd14, 8'd8);
    rd_chk("rst_cksum0", 8'd20, 8'h00);
    rd_chk("rst_status", 8'd17, 8'h00);
    rd_chk("rst_dst0", 8'd0, 8'h00);

    // program basic frame
    for (int k = 0; k < 6; k++) wr(8'(k), 8'(k + 1));
    for (int k = 0; k < 6; k++) wr(8'(k + 6), 8'(k + 10));
    wr(8'd12, 8'h00);
    wr(8'd13, 8'h08);
    wr(8'd14, 8'd3);
    wr(8'd15, 8'h5A);
    rd_chk("rb_dst5", 8'd5, 8'h06);
    @(negedge clk);
    chk("readdata_idle_zero", {24'd0, readdata}, 32'd0);
    rd_chk("rb_src0", 8'd6, 8'h0A);
    rd_chk("rb_eth_hi", 8'd13, 8'h08);
    rd_chk("rb_unmapped19", 8'd19, 8'h00);
    rd_chk("rb_unmapped200", 8'd200, 8'h00);

    // frame with tready held high
    set_payload(8'h5A, 3);
    wr(8'd16, 8'h01);
    run_words(0, 10, 10, 1'b0, cyc);
    chk("cycles_ready", cyc, 10);
    chk("idle_after_frame", {31'd0, tvalid}, 32'd0);
    rd_chk("count1", 8'd18, 8'd1);
    rd_chk("cksum0", 8'd20, 8'h03);
    rd_chk("cksum1", 8'd21, 8'h0E);
    rd_chk("cksum2", 8'd22, 8'h01);
    rd_chk("cksum3", 8'd23, 8'h00);
    rd_chk("status_idle", 8'd17, 8'h00);

    // same frame with tready toggling 0,1,...
    wr(8'd16, 8'h01);
    run_words(0, 10, 10, 1'b1, cyc);
    chk("cycles_toggle", cyc, 20);
    rd_chk("count2", 8'd18, 8'd2);
    rd_chk("cksum_toggle1", 8'd21, 8'h0E);

    // writes to read-only addresses ignored
    wr(8'd18, 8'h55);
    wr(8'd20, 8'hFF);
    rd_chk("ro_count", 8'd18, 8'd2);
    rd_chk("ro_cksum0", 8'd20, 8'h03);

    // zero length acts as one word
    wr(8'd14, 8'd0);
    set_payload(8'h5A, 1);
    wr(8'd16, 8'h01);
    run_words(0, 8, 8, 1'b0, cyc);
    chk("len0_idle", {31'd0, tvalid}, 32'd0);
    rd_chk("len0_cksum0", 8'd20, 8'h00);
    rd_chk("len0_cksum1", 8'd21, 8'h5A);
    rd_chk("len0_cksum2", 8'd22, 8'h00);
    rd_chk("len0_reg", 8'd14, 8'd0);
    rd_chk("count3", 8'd18, 8'd3);

    // busy status and start-while-busy ignored
    wr(8'd14, 8'd1);
    tready = 1'b0;
    wr(8'd16, 8'h01);
    rd_chk("status_busy", 8'd17, 8'h01);
    wr(8'd16, 8'h01);
    run_words(0, 8, 8, 1'b0, cyc);
    rd_chk("status_after_busy", 8'd17, 8'h00);
    rd_chk("count4", 8'd18, 8'd4);

    // continuous mode, stop during third frame
    tready = 1'b0;
    wr(8'd16, 8'h03);
    rd_chk("ctrl_cont", 8'd16, 8'h02);
    rd_chk("status_cont", 8'd17, 8'h03);
    run_words(0, 8, 8, 1'b0, cyc);
    run_words(0, 8, 8, 1'b0, cyc);
    tready = 1'b0;
    chk("cont_f3_tvalid", {31'd0, tvalid}, 32'd1);
    wr(8'd16, 8'h04);
    rd_chk("status_stop_pending", 8'd17, 8'h01);
    run_words(0, 8, 8, 1'b0, cyc);
    chk("stop_idle", {31'd0, tvalid}, 32'd0);
    @(negedge clk);
    chk("stop_stays_idle", {31'd0, tvalid}, 32'd0);
    rd_chk("count7", 8'd18, 8'd7);
    rd_chk("ctrl_after_stop", 8'd16, 8'h00);

    // seed change during payload keeps old seed for the frame in flight
    wr(8'd14, 8'd3);
    set_payload(8'h5A, 3);
    wr(8'd16, 8'h01);
    run_words(0, 8, 10, 1'b0, cyc);
    tready = 1'b0;
    wr(8'd15, 8'h11);
    run_words(8, 2, 10, 1'b0, cyc);
    rd_chk("old_seed_cksum1", 8'd21, 8'h0E);
    set_payload(8'h11, 3);
    wr(8'd16, 8'h01);
    run_words(0, 10, 10, 1'b0, cyc);
    rd_chk("new_seed_cksum0", 8'd20, 8'h03);
    rd_chk("new_seed_cksum1", 8'd21, 8'h33);
    rd_chk("count9", 8'd18, 8'd9);

    // reset during payload word 2
    wr(8'd16, 8'h01);
    run_words(0, 9, 10, 1'b0, cyc);
    tready = 1'b0;
    chk("pre_reset_word", {16'd0, tdata}, 32'h1102);
    reset = 1'b0;
    #1;
    chk("mid_rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("mid_rst_tdata", {16'd0, tdata}, 32'd0);
    chk("mid_rst_tlast", {31'd0, tlast}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    rd_chk("post_rst_count", 8'd18, 8'd0);
    rd_chk("post_rst_cksum0", 8'd20, 8'h00);
    rd_chk("post_rst_cksum1", 8'd21, 8'h00);
    rd_chk("post_rst_len", 8'd14, 8'd8);
    rd_chk("post_rst_seed", 8'd15, 8'h00);
    rd_chk("post_rst_status", 8'd17, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
